ans_seg_display: RTL and testbench
==================================

# ans_seg_display

Downstream display stage for the calculator datapath: converts the 32-bit signed result word from the arithmetic stage into six 7-segment digit patterns for the board's seven-segment displays. The result word carries two in-band marker codes, one for NULL and one for error. Binary-to-BCD conversion is sequential (double-dabble, one shift per clock), so the result registers are fully synchronous to the system clock. The block handles the special codes, the sign, and range checking, and signals completion with a one-cycle pulse.

## Interface
- NULL_CODE, 32'h00CC0000, marker word meaning "no result"; displays all blank
- ERR_CODE, 32'h00EE0000, marker word meaning "error / out of range"; displays "Err"
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- ans  in  32  signed result word from the arithmetic stage; sampled only on an accepted load
- load  in  1  request conversion of ans; accepted only when busy=0
- busy  out  1  high from acceptance until the conversion completes
- done  out  1  one-cycle pulse; seg_n is valid and updated in the same cycle
- seg_n  out  42  six digits × 7 segments, active-low; digit d occupies [7d+6:7d], digit0 is rightmost; bit order within a digit {g,f,e,d,c,b,a}

## Operation
- States:
  - IDLE
  - CLASSIFY
  - SHIFT
  - ENCODE
- IDLE: load=1 latches ans into ans_r, sets busy=1, and moves to CLASSIFY. With busy=1, load is ignored (no queueing).
- CLASSIFY (1 cycle):
  - ans_r==ERR_CODE, or ans_r>999999, or ans_r<-99999: kind=ERR, go to ENCODE.
  - ans_r==NULL_CODE: kind=NULL, go to ENCODE.
  - Otherwise: neg=ans_r[31]; mag=|ans_r| truncated to 20 bits; bcd=24'h0; cnt=20; go to SHIFT.
  - Marker checks take priority over the range check.
- SHIFT: each cycle, add 3 to every BCD nibble ≥5, then shift {bcd,mag} left by 1 and decrement cnt. When cnt reaches 0 after the shift, go to ENCODE. Always exactly 20 cycles.
- ENCODE (1 cycle): register seg_n, pulse done=1, clear busy, return to IDLE.
- Digit glyphs (active-high gfedcba, inverted on output):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F
  - '-'=40, 'E'=79, 'r'=50, blank=00
- NULL display: all six digits blank.
- ERR display: digit2='E', digit1='r', digit0='r'; digits 5..3 blank.
- Numeric display: see Configuration for leading-zero and sign placement. A value of 0 always shows '0' in digit0.
- Arithmetic: the magnitude of -99999..999999 fits in 20 bits. Negation is two's complement on the 32-bit value before truncation.

## Timing
- Reset (async, high):
  - state=IDLE, busy=0, done=0, seg_n=42'h3FFFFFFFFFF (all blank).
  - ans_r, bcd, and cnt are cleared.
- Reset mid-conversion aborts the conversion: no done pulse, and seg_n is blank.
- Let edge k be the edge that accepts load.
  - Numeric path: CLASSIFY at k+1, SHIFT at k+2..k+21, ENCODE at k+22. done and the new seg_n appear after edge k+22 (latency 22). busy is high for 22 cycles.
  - Marker or out-of-range path: done and the new seg_n appear after edge k+2 (latency 2).
- The earliest next accepted load is the edge after done, which is also the first cycle with busy=0. A load asserted during the done cycle is accepted.
- seg_n holds its value between conversions and changes only on a done cycle or on reset.

## Configuration
- LEADING_ZERO_BLANK_EN defined:
  - Leading zeros above the most significant nonzero digit are blank.
  - For a negative value, '-' occupies the digit immediately left of the most significant nonzero digit.
  - Example: -42 displays as blank, blank, blank, '-', '4', '2'.
- LEADING_ZERO_BLANK_EN undefined:
  - All six digits are shown, with zeros.
  - For a negative value, '-' is fixed in digit5.
  - Example: -42 displays as '-','0','0','0','4','2'.
- Both builds show "Err" and NULL identically. Latency is unaffected.

## Test plan
- ans=123456, pulse load → busy high for 22 cycles; done 22 cycles after load; digits 5..0 = 1,2,3,4,5,6.
- ans=32'hFFFFFFD6 (-42) → blanking build: digits 5..3 blank, digit2 '-', digits 1..0 = '4','2'. Non-blanking build: '-',0,0,0,4,2.
- ans=32'h00EE0000, then 1000000, then -100000 → each produces done after 2 cycles and shows "Err". ans=-99999 → '-',9,9,9,9,9 after 22 cycles.
- ans=32'h00CC0000 → done after 2 cycles, seg_n all ones. ans=0 → digit0 '0' and all other digits blank (blanking build).
- load re-pulsed with ans=7 at cycle k+5 of a 123456 conversion → ignored; result still 123456; exactly one done.
- rst asserted at cycle k+10 → busy=0 and seg_n all ones immediately; no done pulse. A load after release converts normally.

Source files
------------

// File: rtl/ans_seg_display_if.sv
// ============================================================================
// ans_seg_display_if : load/result bus between the calculator datapath and
//                      the seven-segment display converter.   Rev 1.0
// ============================================================================
`default_nettype none

interface ans_seg_display_if;
   logic [31:0] ans;
   logic        load;
   logic        busy;
   logic        done;
   logic [41:0] seg_n;

   modport master (output ans, output load, input busy, input done, input seg_n);
   modport slave  (input ans, input load, output busy, output done, output seg_n);
endinterface

`default_nettype wire

// File: rtl/ans_seg_display.sv
// ============================================================================
// ans_seg_display : signed result word -> six active-low 7-segment digits via
//                   serial double-dabble. Option macro: LEADING_ZERO_BLANK_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module ans_seg_display (
   input  wire logic         clk,
   input  wire logic         rst,
   ans_seg_display_if.slave  bus
);

   localparam logic [31:0] NULL_CODE  = 32'h00CC_0000;
   localparam logic [31:0] ERR_CODE   = 32'h00EE_0000;
   localparam logic [4:0]  SHIFT_CNT  = 5'd20;
   localparam logic [41:0] SEG_BLANK  = 42'h3FF_FFFF_FFFF;
   localparam logic [3:0]  CODE_MINUS = 4'hA;
   localparam logic [3:0]  CODE_E     = 4'hB;
   localparam logic [3:0]  CODE_R     = 4'hC;
   localparam logic [3:0]  CODE_BLANK = 4'hF;

   typedef enum logic [1:0] {S_IDLE, S_CLASSIFY, S_SHIFT, S_ENCODE} state_t;
   typedef enum logic [1:0] {K_NUM, K_NULL, K_ERR} kind_t;

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [31:0] ans_q, ans_d;
   logic [23:0] bcd_q, bcd_d;
   logic [19:0] mag_q, mag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_q, neg_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [41:0] seg_n_q, seg_n_d;

   logic [19:0] mag_abs;
   logic        out_of_range;
   logic [23:0] bcd_adj;
   logic [3:0]  digit_code [6];
   logic [41:0] seg_enc;

   function automatic logic [6:0] glyph(input logic [3:0] code);
      case (code)
         4'd0:       glyph = 7'h3F;
         4'd1:       glyph = 7'h06;
         4'd2:       glyph = 7'h5B;
         4'd3:       glyph = 7'h4F;
         4'd4:       glyph = 7'h66;
         4'd5:       glyph = 7'h6D;
         4'd6:       glyph = 7'h7D;
         4'd7:       glyph = 7'h07;
         4'd8:       glyph = 7'h7F;
         4'd9:       glyph = 7'h6F;
         CODE_MINUS: glyph = 7'h40;
         CODE_E:     glyph = 7'h79;
         CODE_R:     glyph = 7'h50;
         default:    glyph = 7'h00;
      endcase
   endfunction

   // Low 20 bits of the two's complement negation equal the truncated magnitude.
   assign mag_abs      = ans_q[31] ? (~ans_q[19:0] + 20'd1) : ans_q[19:0];
   assign out_of_range = ($signed(ans_q) > 32'sd999999) || ($signed(ans_q) < -32'sd99999);

   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 6; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
      int msd;
      msd = 0;
`endif
      for (int i = 0; i < 6; i++) begin
         digit_code[i] = CODE_BLANK;
      end
      case (kind_q)
         K_ERR: begin
            digit_code[2] = CODE_E;
            digit_code[1] = CODE_R;
            digit_code[0] = CODE_R;
         end
         K_NUM: begin
`ifdef LEADING_ZERO_BLANK_EN
            for (int i = 1; i < 6; i++) begin
               if (bcd_q[4*i +: 4] != 4'd0) msd = i;
            end
            for (int i = 0; i < 6; i++) begin
               if (i <= msd) begin
                  digit_code[i] = bcd_q[4*i +: 4];
               end else if (neg_q && (i == msd + 1)) begin
                  digit_code[i] = CODE_MINUS;
               end
            end
`else
            for (int i = 0; i < 6; i++) begin
               digit_code[i] = bcd_q[4*i +: 4];
            end
            if (neg_q) digit_code[5] = CODE_MINUS;
`endif
         end
         default: ;
      endcase
      for (int i = 0; i < 6; i++) begin
         seg_enc[7*i +: 7] = ~glyph(digit_code[i]);
      end
   end

   always_comb begin
      state_d = state_q;
      kind_d  = kind_q;
      ans_d   = ans_q;
      bcd_d   = bcd_q;
      mag_d   = mag_q;
      cnt_d   = cnt_q;
      neg_d   = neg_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      seg_n_d = seg_n_q;
      case (state_q)
         S_IDLE: begin
            if (bus.load) begin
               ans_d   = bus.ans;
               busy_d  = 1'b1;
               state_d = S_CLASSIFY;
            end
         end
         S_CLASSIFY: begin
            // NULL_CODE itself lies above the numeric range, so markers go first.
            if (ans_q == ERR_CODE) begin
               kind_d  = K_ERR;
               state_d = S_ENCODE;
            end else if (ans_q == NULL_CODE) begin
               kind_d  = K_NULL;
               state_d = S_ENCODE;
            end else if (out_of_range) begin
               kind_d  = K_ERR;
               state_d = S_ENCODE;
            end else begin
               kind_d  = K_NUM;
               neg_d   = ans_q[31];
               mag_d   = mag_abs;
               bcd_d   = 24'h0;
               cnt_d   = SHIFT_CNT;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            bcd_d = (bcd_adj << 1) | {23'd0, mag_q[19]};
            mag_d = mag_q << 1;
            cnt_d = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = S_ENCODE;
         end
         S_ENCODE: begin
            seg_n_d = seg_enc;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         kind_q  <= K_NUM;
         ans_q   <= 32'd0;
         bcd_q   <= 24'd0;
         mag_q   <= 20'd0;
         cnt_q   <= 5'd0;
         neg_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         seg_n_q <= SEG_BLANK;
      end else begin
         state_q <= state_d;
         kind_q  <= kind_d;
         ans_q   <= ans_d;
         bcd_q   <= bcd_d;
         mag_q   <= mag_d;
         cnt_q   <= cnt_d;
         neg_q   <= neg_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         seg_n_q <= seg_n_d;
      end
   end

   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.seg_n = seg_n_q;

endmodule

`default_nettype wire

// File: tb/tb_ans_seg_display.sv
// ============================================================================
// tb_ans_seg_display : scoreboard bench for ans_seg_display (either build of
//                      LEADING_ZERO_BLANK_EN).   Rev 1.0
// ============================================================================
`default_nettype none

module tb_ans_seg_display;

   localparam logic [31:0] NULL_CODE = 32'h00CC_0000;
   localparam logic [31:0] ERR_CODE  = 32'h00EE_0000;
   localparam logic [41:0] ALL_BLANK = 42'h3FF_FFFF_FFFF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ans_seg_display_if bus_if ();

   ans_seg_display dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   typedef struct {
      logic [41:0] seg;
      int          lat;
      int          k;
      int          busy0;
   } exp_t;

   exp_t sb[$];
   int   n_checks   = 0;
   int   n_errors   = 0;
   int   cyc        = 0;
   int   busy_total = 0;
   int   done_count = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [6:0] gl(input int c);
      case (c)
         0:  gl = 7'h3F;
         1:  gl = 7'h06;
         2:  gl = 7'h5B;
         3:  gl = 7'h4F;
         4:  gl = 7'h66;
         5:  gl = 7'h6D;
         6:  gl = 7'h7D;
         7:  gl = 7'h07;
         8:  gl = 7'h7F;
         9:  gl = 7'h6F;
         10: gl = 7'h40;
         11: gl = 7'h79;
         12: gl = 7'h50;
         default: gl = 7'h00;
      endcase
   endfunction

   function automatic bit is_special(input logic [31:0] a);
      int v;
      v = $signed(a);
      return (a == ERR_CODE) || (a == NULL_CODE) || (v > 999999) || (v < -99999);
   endfunction

   function automatic logic [41:0] model(input logic [31:0] a);
      int          v, m, msd;
      int          d    [6];
      int          code [6];
      bit          neg;
      logic [41:0] r;
      v = $signed(a);
      for (int i = 0; i < 6; i++) code[i] = -1;
      if (a == NULL_CODE) begin
      end else if ((a == ERR_CODE) || (v > 999999) || (v < -99999)) begin
         code[2] = 11; code[1] = 12; code[0] = 12;
      end else begin
         neg = (v < 0);
         m   = neg ? -v : v;
         for (int i = 0; i < 6; i++) begin
            d[i] = m % 10;
            m    = m / 10;
         end
`ifdef LEADING_ZERO_BLANK_EN
         msd = 0;
         for (int i = 0; i < 6; i++) if (d[i] != 0) msd = i;
         for (int i = 0; i <= msd; i++) code[i] = d[i];
         if (neg) code[msd+1] = 10;
`else
         msd = 0;
         for (int i = 0; i < 6; i++) code[i] = d[i];
         if (neg) code[5] = 10;
`endif
      end
      for (int i = 0; i < 6; i++) r[7*i +: 7] = ~gl(code[i]);
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      exp_t e;
      if (bus_if.busy) busy_total++;
      if (bus_if.done) begin
         done_count++;
         if (sb.size() == 0) begin
            check("unexpected_done", 64'(sb.size()), 64'd1);
         end else begin
            e = sb.pop_front();
            check("seg_n", bus_if.seg_n, e.seg);
            check("latency", 64'(cyc - e.k), 64'(e.lat));
            check("busy_cycles", 64'(busy_total - e.busy0), 64'(e.lat));
         end
      end
   end

   task automatic do_load(input logic [31:0] a);
      exp_t e;
      int   g;
      g = 0;
      while (bus_if.busy && g < 50) begin
         @(negedge clk);
         g++;
      end
      bus_if.ans  = a;
      bus_if.load = 1'b1;
      e.seg   = model(a);
      e.lat   = is_special(a) ? 2 : 22;
      e.k     = cyc + 1;
      e.busy0 = busy_total;
      sb.push_back(e);
      @(posedge clk);
      #1 bus_if.load = 1'b0;
   endtask

   task automatic wait_done(input int bound);
      int start, n;
      start = done_count;
      n     = 0;
      while (done_count == start && n < bound) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("done_seen", 64'(done_count - start), 64'd1);
   endtask

   logic [31:0] vec [10] = '{32'd123456, 32'hFFFF_FFD6, ERR_CODE, 32'd1000000,
                             32'hFFFE_7960, 32'hFFFE_7961, NULL_CODE, 32'd0,
                             32'd999999, 32'h8000_0000};

   initial begin
      int dc;
      rst         = 1'b1;
      bus_if.load = 1'b0;
      bus_if.ans  = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_seg_n", bus_if.seg_n, ALL_BLANK);
      check("rst_busy", 64'(bus_if.busy), 64'd0);
      check("rst_done", 64'(bus_if.done), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Each new load lands in the previous done cycle.
      foreach (vec[i]) begin
         do_load(vec[i]);
         wait_done(40);
      end

      // A load while busy is dropped.
      dc = done_count;
      do_load(32'd123456);
      repeat (3) @(negedge clk);
      bus_if.ans  = 32'd7;
      bus_if.load = 1'b1;
      @(posedge clk);
      #1 bus_if.load = 1'b0;
      wait_done(40);
      repeat (30) @(negedge clk);
      check("single_done", 64'(done_count - dc), 64'd1);

      // Asynchronous reset mid-conversion.
      dc = done_count;
      do_load(32'd123456);
      repeat (8) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_busy", 64'(bus_if.busy), 64'd0);
      check("abort_seg_n", bus_if.seg_n, ALL_BLANK);
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (30) @(negedge clk);
      check("abort_no_done", 64'(done_count - dc), 64'd0);
      do_load(32'd5);
      wait_done(40);
      do_load(32'hFFFF_FFFF);
      wait_done(40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
